regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's WRITE_PORTS write ports among NUM_REQ writeback requesters (functional units / CDB sources) in the OoO core.
- Uses round-robin priority with valid/ready handshakes.
- Resolves same-address conflicts so that no two ports write one register in the same cycle.
- Registers the selected writes and drives the register file's we/waddr/wdata one cycle after acceptance.

Parameters:
- NUM_REQ, 4, number of writeback requesters.
- WRITE_PORTS, 2, number of register file write ports driven.
- REG_NUM, 32, number of architectural/physical registers. Address width AW = $clog2(REG_NUM).
- DATA_WIDTH, 32, write data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  requester has a pending write
- req_addr  in  NUM_REQ x AW  destination register per requester
- req_data  in  NUM_REQ x DATA_WIDTH  write data per requester
- req_ready  out  NUM_REQ  request accepted this cycle (combinational)
- wb_we  out  WRITE_PORTS  register file write enables (registered)
- wb_waddr  out  WRITE_PORTS x AW  register file write addresses (registered)
- wb_wdata  out  WRITE_PORTS x DATA_WIDTH  register file write data (registered)

Behaviour:
- Reset: wb_we=0, wb_waddr=0, wb_wdata=0, rr_ptr=0 (and stall_cnt=0 if enabled). A write registered before reset is discarded and never emitted.
- Handshake: a request is accepted in cycle T when req_valid[i] && req_ready[i].
  - Requester holds valid/addr/data stable until accepted.
  - req_valid must not depend on req_ready.
  - req_ready may depend combinationally on all req_valid/req_addr.
- Grant scan each cycle, for i=0..NUM_REQ-1 with idx=(rr_ptr+i) mod NUM_REQ. Grant idx if req_valid[idx] and one of:
  - (a) req_addr[idx]==0: always granted, consumes no port, emits no write;
  - (b) fewer than WRITE_PORTS nonzero grants so far AND req_addr[idx] differs from every nonzero address already granted this cycle.
- Port assignment: the k-th nonzero grant in scan order goes to port k. Unused ports have wb_we[k]=0; their waddr/wdata are don't-care (hold 0).
- Latency: accepted in T → wb_we/wb_waddr/wb_wdata valid in T+1 for exactly one cycle. No backpressure from the register file.
- rr_ptr update: if any nonzero grant, rr_ptr ← (index of last nonzero grant in scan order + 1) mod NUM_REQ. Otherwise unchanged.
- Conflict: a losing same-address requester keeps req_ready=0 and retries. Its older/newer ordering is the producer's concern; the rename stage guarantees unique destinations per in-flight op.
- No valid requests: req_ready=0, wb_we=0 next cycle.
- rr_ptr wrap: NUM_REQ-1 → 0.

Optional Feature:
- Macro REGFILE_WB_ARB_STATS_EN.
- When defined: adds output stall_cnt (32 bits). It increments, wrapping at 2^32-1 → 0, in each cycle where at least one req_valid[i]=1 with req_ready[i]=0. Reset value 0.
- When undefined: port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package regfile_pkg holds:
  - reg_addr_t (logic [AW-1:0]);
  - wb_req_t struct {addr, data};
  - localparam ZERO_REG = 0.
- Sub-module wb_port_picker (purely combinational): takes valid/addr/rr_ptr and returns the grant vector, per-port source index, per-port enable and next rr_ptr.
- The top level holds the registers, the handshake and the optional counter.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 → req_ready=0 during reset. Outputs are all 0 after reset. First post-reset grants start at idx 0.
- Four requests, addrs 1,2,3,4, rr_ptr=0 → req_ready=0011. Next cycle wb_we=11, port0 addr1, port1 addr2, rr_ptr=2. Holding requests 2,3 → ready=1100, then writes addr3, addr4.
- Conflict: req0 addr5, req1 addr5, req2 addr6 (rr_ptr=0) → ready=101. Port0 addr5 data req0, port1 addr6. Next cycle req1 granted alone → port0 addr5.
- Zero register: req0 addr0, req1 addr3, req2 addr4, req3 addr7 → ready=0111. Ports write addr3, addr4 only. rr_ptr=3. Next cycle req3 granted.
- Fairness: all four continuously valid with distinct addrs → every requester granted at least once per 2 cycles. stall_cnt (if REGFILE_WB_ARB_STATS_EN) increments every cycle.
- Reset mid-operation: accept req0 addr9 in T, assert rst at T's edge → wb_we stays 0 at T+1 and no write to addr9 occurs.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Register 0 is hard-wired zero, so writes to it are absorbed without using a port.
package regfile_pkg;

  localparam int REG_NUM    = 32;
  localparam int AW         = $clog2(REG_NUM);
  localparam int DATA_WIDTH = 32;
  localparam int ZERO_REG   = 0;

  typedef logic [AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t             addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  // Increment modulo n, used for round-robin pointer wrap.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: requesters present valid/addr/data, the arbiter answers with ready
// and drives the register file write ports one cycle after acceptance.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int WRITE_PORTS = 2,
  parameter int AW          = regfile_pkg::AW,
  parameter int DATA_WIDTH  = regfile_pkg::DATA_WIDTH
);

  // Handshake: a request transfers in any cycle where req_valid[i] && req_ready[i].
  // The requester holds valid/addr/data stable until that cycle and never derives
  // req_valid from req_ready; req_ready is combinational from all valid/addr inputs.
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][AW-1:0]         req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;

  logic [WRITE_PORTS-1:0]                 wb_we;
  logic [WRITE_PORTS-1:0][AW-1:0]         wb_waddr;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wb_wdata;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wb_we, wb_waddr, wb_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wb_we, wb_waddr, wb_wdata
  );

endinterface

// File: rtl/regfile_wb_arbiter_picker.sv
// Combinational round-robin grant scan: zero-register writes are free, nonzero writes
// fill ports in scan order while skipping addresses already claimed this cycle.
module wb_port_picker
  import regfile_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WRITE_PORTS = 2,
  parameter int AW          = regfile_pkg::AW,
  parameter int PW          = 2
) (
  input  logic [NUM_REQ-1:0]             valid,
  input  logic [NUM_REQ-1:0][AW-1:0]     addr,
  input  logic [PW-1:0]                  rr_ptr,
  output logic [NUM_REQ-1:0]             grant,
  output logic [WRITE_PORTS-1:0][PW-1:0] port_src,
  output logic [WRITE_PORTS-1:0]         port_en,
  output logic [PW-1:0]                  rr_next
);

  logic [AW-1:0] port_addr [WRITE_PORTS];
  logic [PW-1:0] idx;
  logic [PW-1:0] last;
  logic          hit;
  logic          any_nz;
  int            used;

  always_comb begin
    grant     = '0;
    port_src  = '0;
    port_en   = '0;
    port_addr = '{default: '0};
    idx       = '0;
    last      = rr_ptr;
    hit       = 1'b0;
    any_nz    = 1'b0;
    used      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (valid[idx]) begin
        if (addr[idx] == AW'(ZERO_REG)) begin
          grant[idx] = 1'b1;
        end else if (used < WRITE_PORTS) begin
          hit = 1'b0;
          for (int k = 0; k < WRITE_PORTS; k++) begin
            if (port_en[k] && port_addr[k] == addr[idx]) hit = 1'b1;
          end
          if (!hit) begin
            grant[idx]      = 1'b1;
            port_en[used]   = 1'b1;
            port_src[used]  = idx;
            port_addr[used] = addr[idx];
            used            = used + 1;
            last            = idx;
            any_nz          = 1'b1;
          end
        end
      end
    end
    // The requester after the last port winner gets first pick next cycle.
    rr_next = any_nz ? PW'(wrap_inc(int'(last), NUM_REQ)) : rr_ptr;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares WRITE_PORTS register-file write ports among NUM_REQ requesters.
// Define REGFILE_WB_ARB_STATS_EN to add the 32-bit stall_cnt output.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WRITE_PORTS = 2,
  parameter int REG_NUM     = regfile_pkg::REG_NUM,
  parameter int DATA_WIDTH  = regfile_pkg::DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
`ifdef REGFILE_WB_ARB_STATS_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int AW = $clog2(REG_NUM);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]                  rr_ptr;
  logic [PW-1:0]                  rr_next;
  logic [NUM_REQ-1:0]             grant;
  logic [WRITE_PORTS-1:0][PW-1:0] port_src;
  logic [WRITE_PORTS-1:0]         port_en;

  wb_port_picker #(
    .NUM_REQ     (NUM_REQ),
    .WRITE_PORTS (WRITE_PORTS),
    .AW          (AW),
    .PW          (PW)
  ) u_picker (
    .valid    (bus.req_valid),
    .addr     (bus.req_addr),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .port_src (port_src),
    .port_en  (port_en),
    .rr_next  (rr_next)
  );

  // Nothing is accepted while in reset, so a request seen at the reset edge is retried.
  assign bus.req_ready = rst ? '0 : grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_we    <= '0;
      bus.wb_waddr <= '0;
      bus.wb_wdata <= '0;
      rr_ptr       <= '0;
    end else begin
      for (int k = 0; k < WRITE_PORTS; k++) begin
        bus.wb_we[k]    <= port_en[k];
        bus.wb_waddr[k] <= port_en[k] ? bus.req_addr[port_src[k]] : '0;
        bus.wb_wdata[k] <= port_en[k] ? bus.req_data[port_src[k]] : '0;
      end
      rr_ptr <= rr_next;
    end
  end

`ifdef REGFILE_WB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (|(bus.req_valid & ~bus.req_ready)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corners and random traffic
// checked against a scan-order reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NR = 4;
  localparam int WP = 2;
  localparam int AWB = 5;
  localparam int DW = 32;
  localparam int EW = 2 + 2 * AWB + 2 * DW;

  typedef struct {
    logic [NR-1:0]          v;
    logic [NR-1:0][AWB-1:0] a;
    logic [NR-1:0]          rdy;
    logic [WP-1:0]          we;
    logic [AWB-1:0]         a0;
    logic [AWB-1:0]         a1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .WRITE_PORTS(WP), .AW(AWB), .DATA_WIDTH(DW)) bus ();

`ifdef REGFILE_WB_ARB_STATS_EN
  logic [31:0] stall_cnt;
  regfile_wb_arbiter #(.NUM_REQ(NR), .WRITE_PORTS(WP), .REG_NUM(32), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt));
`else
  regfile_wb_arbiter #(.NUM_REQ(NR), .WRITE_PORTS(WP), .REG_NUM(32), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;
  int m_rr = 0;
  logic [31:0] m_stall = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] dut_wb();
    return {bus.wb_we, bus.wb_waddr[0], bus.wb_waddr[1], bus.wb_wdata[0], bus.wb_wdata[1]};
  endfunction

  // Reference: walk requesters starting at rr, give away free zero-reg writes and
  // hand out ports to the first distinct nonzero addresses found.
  function automatic void model(input logic [NR-1:0] v, input logic [NR-1:0][AWB-1:0] a,
                                input logic [NR-1:0][DW-1:0] d, input int rr,
                                output logic [NR-1:0] rdy, output logic [EW-1:0] wb,
                                output int rr_n);
    int winners[$];
    logic [WP-1:0] we;
    logic [AWB-1:0] wa [WP];
    logic [DW-1:0] wd [WP];
    bool_loop: for (int i = 0; i < NR; i++) begin
      int r = (rr + i) % NR;
      bit taken = 0;
      if (!v[r]) continue;
      if (a[r] == 0) begin
        rdy[r] = 1'b1;
        continue;
      end
      foreach (winners[w]) if (a[winners[w]] == a[r]) taken = 1;
      if (winners.size() < WP && !taken) winners.push_back(r);
    end
    rdy = (rdy === 'x) ? '0 : rdy;
    rdy = '0;
    for (int r = 0; r < NR; r++) if (v[r] && a[r] == 0) rdy[r] = 1'b1;
    foreach (winners[w]) rdy[winners[w]] = 1'b1;
    for (int k = 0; k < WP; k++) begin
      we[k] = (k < winners.size());
      wa[k] = we[k] ? a[winners[k]] : '0;
      wd[k] = we[k] ? d[winners[k]] : '0;
    end
    wb = {we, wa[0], wa[1], wd[0], wd[1]};
    rr_n = (winners.size() > 0) ? (winners[winners.size()-1] + 1) % NR : rr;
  endfunction

  // One cycle: present inputs, check ready, clock, check the registered writes.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0][AWB-1:0] a,
                      input logic [NR-1:0][DW-1:0] d, output logic [NR-1:0] rdy_act);
    logic [NR-1:0] exp_rdy;
    logic [EW-1:0] wb;
    int rr_n;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    #1;
    model(v, a, d, m_rr, exp_rdy, wb, rr_n);
    check("ready", EW'(bus.req_ready), EW'(exp_rdy));
    rdy_act = bus.req_ready;
    exp_q.push_back(wb);
    m_rr = rr_n;
    if (|(v & ~exp_rdy)) m_stall = m_stall + 1;
    @(posedge clk);
    #1;
    check("wb", dut_wb(), exp_q.pop_front());
`ifdef REGFILE_WB_ARB_STATS_EN
    check("stall_cnt", EW'(stall_cnt), EW'(m_stall));
`endif
  endtask

  function automatic logic [NR-1:0][DW-1:0] mk_data(input logic [NR-1:0][AWB-1:0] a);
    logic [NR-1:0][DW-1:0] d;
    for (int i = 0; i < NR; i++) d[i] = 32'hD000_0000 | (i << 8) | 32'(a[i]);
    return d;
  endfunction

  vec_t tbl[11];
  logic [NR-1:0] rdy;
  logic [NR-1:0] prev_rdy;
  logic [NR-1:0] pend;
  logic [NR-1:0][AWB-1:0] pa;
  logic [NR-1:0][DW-1:0] pd;

  initial begin
    tbl[0]  = '{4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0011, 2'b11, 5'd1, 5'd2};
    tbl[1]  = '{4'b1100, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1100, 2'b11, 5'd3, 5'd4};
    tbl[2]  = '{4'b0111, {5'd0, 5'd6, 5'd5, 5'd5}, 4'b0101, 2'b11, 5'd5, 5'd6};
    tbl[3]  = '{4'b0010, {5'd0, 5'd6, 5'd5, 5'd5}, 4'b0010, 2'b01, 5'd5, 5'd0};
    tbl[4]  = '{4'b1000, {5'd8, 5'd0, 5'd0, 5'd0}, 4'b1000, 2'b01, 5'd8, 5'd0};
    tbl[5]  = '{4'b1111, {5'd7, 5'd4, 5'd3, 5'd0}, 4'b0111, 2'b11, 5'd3, 5'd4};
    tbl[6]  = '{4'b1000, {5'd7, 5'd4, 5'd3, 5'd0}, 4'b1000, 2'b01, 5'd7, 5'd0};
    tbl[7]  = '{4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 2'b00, 5'd0, 5'd0};
    tbl[8]  = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0001, 2'b00, 5'd0, 5'd0};
    tbl[9]  = '{4'b1111, {5'd9, 5'd9, 5'd9, 5'd9}, 4'b0001, 2'b01, 5'd9, 5'd0};
    tbl[10] = '{4'b1111, {5'd9, 5'd9, 5'd9, 5'd9}, 4'b0010, 2'b01, 5'd9, 5'd0};

    // Reset with every requester asserting valid: nothing may be accepted.
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    bus.req_data  = mk_data(bus.req_addr);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("reset_ready", EW'(bus.req_ready), '0);
      check("reset_wb", dut_wb(), '0);
    end
    rst = 1'b0;

    foreach (tbl[t]) begin
      step(tbl[t].v, tbl[t].a, mk_data(tbl[t].a), rdy);
      check($sformatf("tbl%0d_ready", t), EW'(rdy), EW'(tbl[t].rdy));
      check($sformatf("tbl%0d_we", t), EW'(bus.wb_we), EW'(tbl[t].we));
      check($sformatf("tbl%0d_addr", t), EW'({bus.wb_waddr[0], bus.wb_waddr[1]}),
            EW'({tbl[t].a0, tbl[t].a1}));
    end

    // Fairness: all four pending with distinct addresses every cycle.
    prev_rdy = '0;
    for (int c = 0; c < 6; c++) begin
      pa = {5'd13, 5'd12, 5'd11, 5'd10};
      step(4'b1111, pa, mk_data(pa), rdy);
      if (c > 0) check("fair_window", EW'(prev_rdy | rdy), EW'(4'b1111));
      prev_rdy = rdy;
    end

    // Random traffic with small address range to provoke conflicts and zero-reg writes.
    pend = '0;
    pa = '0;
    pd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60) begin
          pend[i] = 1'b1;
          pa[i] = AWB'($urandom_range(0, 7));
          pd[i] = $urandom;
        end
      end
      step(pend, pa, pd, rdy);
      pend = pend & ~rdy;
    end

    // Reset arriving in the cycle a write is offered: the write must never appear.
    pa = {5'd0, 5'd0, 5'd0, 5'd9};
    bus.req_valid = 4'b0001;
    bus.req_addr  = pa;
    bus.req_data  = mk_data(pa);
    #1;
    check("pre_reset_ready", EW'(bus.req_ready), EW'(4'b0001));
    rst = 1'b1;
    #1;
    check("in_reset_ready", EW'(bus.req_ready), '0);
    @(posedge clk);
    #1;
    check("midreset_wb", dut_wb(), '0);
    bus.req_valid = '0;
    rst = 1'b0;
    exp_q.delete();
    m_rr = 0;
    m_stall = 0;
    @(posedge clk);
    #1;
    check("post_reset_wb", dut_wb(), '0);
`ifdef REGFILE_WB_ARB_STATS_EN
    check("post_reset_stall", EW'(stall_cnt), '0);
`endif
    pa = {5'd4, 5'd3, 5'd2, 5'd1};
    step(4'b1111, pa, mk_data(pa), rdy);
    check("post_reset_first", EW'(rdy), EW'(4'b0011));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
